// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receive and transmit blocks.
//   - state_t    : receiver FSM state encoding (3 bits)
//   - OVERSAMPLE : s_tick pulses per bit period
//   - MID_START  : s_tick count at which the start bit is re-checked
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//   Free-running divider.  It produces a one-clk s_tick every DVSR clocks
//   (16x the baud rate).  The transmitter instantiates the same divider.
//   Parameters: DVSR (>= 2), DVSR_W (must hold DVSR-1)
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous, active-high reset; clears the counter
//     s_tick out high for one clk when the count equals DVSR-1
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  output logic s_tick
);

  localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign s_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART serial receiver.  It samples rx at 16x baud, filters false starts and
//   shifts in DBIT data bits LSB first.  It then checks the stop bit and
//   reports the result with one-clk pulses.
//   Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after
//   the data bits.  Without that macro, parity_err is tied to 0.
//   Parameters: DBIT (5..8), SB_TICK (stop-bit ticks), DVSR, DVSR_W
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous, active-high reset
//     rx           in   asynchronous serial line, idle high
//     dout         out  last good byte, held until the next good frame
//     rx_done_tick out  one-clk pulse: dout is new
//     frame_err    out  one-clk pulse: stop bit sampled low
//     parity_err   out  one-clk pulse: parity mismatch
//     busy         out  FSM is not in IDLE
//   Consumer interface: there is no ready signal.  The downstream buffer must
//   accept dout in every cycle where rx_done_tick is high.  The three pulses
//   are registered and mutually exclusive.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int SCNT_W = 5;
  localparam int NCNT_W = 3;

  localparam logic [SCNT_W-1:0] MID_LAST  = SCNT_W'(MID_START - 1);
  localparam logic [SCNT_W-1:0] BIT_LAST  = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] STOP_LAST = SCNT_W'(SB_TICK - 1);
  localparam logic [NCNT_W-1:0] DATA_LAST = NCNT_W'(DBIT - 1);

  logic s_tick;

  baud_tick_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick)
  );

  // Two-flop synchronizer.  The flops reset to 1 (line idle) so that leaving
  // reset does not create a false start edge.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t            state_q, state_d;
  logic [SCNT_W-1:0] s_cnt_q, s_cnt_d;
  logic [NCNT_W-1:0] n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              par_bad;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;

  // Even parity: the XOR of the data bits and the parity bit must be 0.
  assign par_bad = (^b_q) ^ par_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      ST_START: begin
        // The start bit is re-checked near mid-bit.  A short glitch that is
        // gone by then is dropped without any pulse.
        if (s_tick) begin
          if (s_cnt_q == MID_LAST) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            b_d     = {rx_s_q, b_q[DBIT-1:1]};
            if (n_cnt_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            par_d   = rx_s_q;
            state_d = ST_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            if (rx_s_q) begin
              state_d = ST_IDLE;
              if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                perr_d = 1'b1;
`endif
              end else begin
                dout_d = b_q;
                done_d = 1'b1;
              end
            end else begin
              // Stop bit low: report once, then wait for the line to return
              // high so that a held-low line cannot produce new frames.
              ferr_d  = 1'b1;
              state_d = ST_WAIT_HIGH;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
